// File: rtl/mna_stamper.sv
// mna_stamper: collects a stream of circuit element stamps (conductances and
// current sources) into a working nodal matrix Aw and vector bw. On the last
// stamp of a frame it publishes an A/b snapshot and pulses the solver reset.
//
// Ports
//   clk           system clock
//   I_RST         synchronous reset, active-high
//   stamp_valid   stamp present on the stamp_* inputs
//   stamp_ready   stamp accepted when valid && ready at rising clk
//   stamp_type    0 = conductance a<->b, 1 = current source b->a
//   stamp_node_a  first node index (SIZE = ground)
//   stamp_node_b  second node index (SIZE = ground)
//   stamp_value   G or I, signed Q(PRECISION.POINT)
//   stamp_last    final stamp of the frame
//   A             published matrix, row-major, [i][j] at ((i*SIZE+j)*W)
//   b             published right-hand-side vector
//   solver_rstn   active-low solver reset, low one cycle per publish
//   frame_valid   a frame has been published since reset
//   frame_sat     published frame contained a saturated sum
//   frame_err     published frame contained a dropped stamp
//   frame_count   number of published frames, wraps at 16 bits
module mna_stamper #(
    parameter int unsigned SIZE      = 3,
    parameter int unsigned PRECISION = 24,
    parameter int unsigned POINT     = 12,
    parameter int unsigned NW        = $clog2(SIZE + 1)
) (
    input  logic                                        clk,
    input  logic                                        I_RST,
    input  logic                                        stamp_valid,
    output logic                                        stamp_ready,
    input  logic                                        stamp_type,
    input  logic [NW-1:0]                               stamp_node_a,
    input  logic [NW-1:0]                               stamp_node_b,
    input  logic signed [PRECISION+POINT-1:0]           stamp_value,
    input  logic                                        stamp_last,
    output logic [SIZE*SIZE*(PRECISION+POINT)-1:0]      A,
    output logic [SIZE*(PRECISION+POINT)-1:0]           b,
    output logic                                        solver_rstn,
    output logic                                        frame_valid,
    output logic                                        frame_sat,
    output logic                                        frame_err,
    output logic [15:0]                                 frame_count
);

    localparam int unsigned W = PRECISION + POINT;

    typedef enum logic [1:0] {
        S_CLEAR  = 2'd0,
        S_ACCUM  = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // Sign-extended add/subtract one bit wider than the operands.
    function automatic logic [W:0] ext_add(input logic [W-1:0] x,
                                           input logic [W-1:0] y,
                                           input logic         sub);
        logic [W:0] xe;
        logic [W:0] ye;
        xe = {x[W-1], x};
        ye = {y[W-1], y};
        return sub ? (xe - ye) : (xe + ye);
    endfunction

    // Clamp a W+1-bit sum back into the signed W-bit range.
    function automatic logic [W-1:0] clamp(input logic [W:0] s);
        if (s[W] != s[W-1]) begin
            return s[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
        return s[W-1:0];
    endfunction

    state_t r_state;
    state_t w_state_next;
    logic   r_ready;
    logic   w_ready_next;
    logic   r_rstn;
    logic   w_rstn_next;

    logic [W-1:0] r_aw      [SIZE][SIZE];
    logic [W-1:0] w_aw_next [SIZE][SIZE];
    logic [W-1:0] r_bw      [SIZE];
    logic [W-1:0] w_bw_next [SIZE];
    logic         r_sat_st;
    logic         r_err_st;

    logic [SIZE*SIZE*W-1:0] r_a_pub;
    logic [SIZE*W-1:0]      r_b_pub;
    logic                   r_fvalid;
    logic                   r_fsat;
    logic                   r_ferr;
    logic [15:0]            r_fcount;

    logic        w_accept;
    logic        w_bad;
    logic        w_apply;
    logic        w_sat_hit;
    logic        w_hit;
    logic        w_sub;
    logic [W:0]  w_sum;
    int unsigned w_ia;
    int unsigned w_ib;

    // State register plus the registered handshake and solver-reset outputs.
    always_ff @(posedge clk) begin
        if (I_RST) begin
            r_state <= S_CLEAR;
            r_ready <= 1'b0;
            r_rstn  <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_ready <= w_ready_next;
            r_rstn  <= w_rstn_next;
        end
    end

    // Next state; solver reset drops for the CLEAR cycle that follows COMMIT.
    always_comb begin
        w_state_next = r_state;
        w_ready_next = 1'b0;
        w_rstn_next  = 1'b1;
        case (r_state)
            S_CLEAR:  w_state_next = S_ACCUM;
            S_ACCUM:  if (w_accept && stamp_last) w_state_next = S_COMMIT;
            S_COMMIT: begin
                w_state_next = S_CLEAR;
                w_rstn_next  = 1'b0;
            end
            default:  w_state_next = S_CLEAR;
        endcase
        w_ready_next = (w_state_next == S_ACCUM);
    end

    // Stamp decode and saturating update of the working set.
    always_comb begin
        w_accept  = stamp_valid && r_ready;
        w_ia      = 32'(stamp_node_a);
        w_ib      = 32'(stamp_node_b);
        w_bad     = (w_ia > SIZE) || (w_ib > SIZE);
        // Same node on both ends contributes nothing; ground never matches a row.
        w_apply   = w_accept && !w_bad && (w_ia != w_ib);
        w_sat_hit = 1'b0;
        w_hit     = 1'b0;
        w_sub     = 1'b0;
        w_sum     = '0;

        for (int unsigned i = 0; i < SIZE; i++) begin
            for (int unsigned j = 0; j < SIZE; j++) begin
                w_aw_next[i][j] = r_aw[i][j];
                w_hit = 1'b0;
                w_sub = 1'b0;
                if (w_apply && !stamp_type) begin
                    if ((i == j) && ((i == w_ia) || (i == w_ib))) begin
                        w_hit = 1'b1;
                    end else if (((i == w_ia) && (j == w_ib)) ||
                                 ((i == w_ib) && (j == w_ia))) begin
                        w_hit = 1'b1;
                        w_sub = 1'b1;
                    end
                end
                if (w_hit) begin
                    w_sum           = ext_add(r_aw[i][j], stamp_value, w_sub);
                    w_aw_next[i][j] = clamp(w_sum);
                    w_sat_hit       = w_sat_hit | (w_sum[W] ^ w_sum[W-1]);
                end
            end
        end

        for (int unsigned i = 0; i < SIZE; i++) begin
            w_bw_next[i] = r_bw[i];
            w_hit = 1'b0;
            w_sub = 1'b0;
            if (w_apply && stamp_type) begin
                if (i == w_ia) begin
                    w_hit = 1'b1;
                end else if (i == w_ib) begin
                    w_hit = 1'b1;
                    w_sub = 1'b1;
                end
            end
            if (w_hit) begin
                w_sum        = ext_add(r_bw[i], stamp_value, w_sub);
                w_bw_next[i] = clamp(w_sum);
                w_sat_hit    = w_sat_hit | (w_sum[W] ^ w_sum[W-1]);
            end
        end
    end

    // Working set, sticky flags and the published snapshot.
    always_ff @(posedge clk) begin
        if (I_RST) begin
            for (int unsigned i = 0; i < SIZE; i++) begin
                for (int unsigned j = 0; j < SIZE; j++) begin
                    r_aw[i][j] <= '0;
                end
                r_bw[i] <= '0;
            end
            r_sat_st <= 1'b0;
            r_err_st <= 1'b0;
            r_a_pub  <= '0;
            r_b_pub  <= '0;
            r_fvalid <= 1'b0;
            r_fsat   <= 1'b0;
            r_ferr   <= 1'b0;
            r_fcount <= '0;
        end else begin
            case (r_state)
                S_CLEAR: begin
                    for (int unsigned i = 0; i < SIZE; i++) begin
                        for (int unsigned j = 0; j < SIZE; j++) begin
                            r_aw[i][j] <= '0;
                        end
                        r_bw[i] <= '0;
                    end
                    r_sat_st <= 1'b0;
                    r_err_st <= 1'b0;
                end
                S_ACCUM: begin
                    for (int unsigned i = 0; i < SIZE; i++) begin
                        for (int unsigned j = 0; j < SIZE; j++) begin
                            r_aw[i][j] <= w_aw_next[i][j];
                        end
                        r_bw[i] <= w_bw_next[i];
                    end
                    if (w_accept && w_bad) r_err_st <= 1'b1;
                    if (w_sat_hit)         r_sat_st <= 1'b1;
                end
                S_COMMIT: begin
                    for (int unsigned i = 0; i < SIZE; i++) begin
                        for (int unsigned j = 0; j < SIZE; j++) begin
                            r_a_pub[(i*SIZE+j)*W +: W] <= r_aw[i][j];
                        end
                        r_b_pub[i*W +: W] <= r_bw[i];
                    end
                    r_fvalid <= 1'b1;
                    r_fsat   <= r_sat_st;
                    r_ferr   <= r_err_st;
                    r_fcount <= r_fcount + 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign stamp_ready = r_ready;
    assign solver_rstn = r_rstn;
    assign A           = r_a_pub;
    assign b           = r_b_pub;
    assign frame_valid = r_fvalid;
    assign frame_sat   = r_fsat;
    assign frame_err   = r_ferr;
    assign frame_count = r_fcount;

endmodule

// File: tb/tb_mna_stamper.sv
// Bench for mna_stamper: directed stamp frames, a behavioural nodal-analysis
// model checked against every output on every falling edge, and literal
// expectations after each frame.
module tb_mna_stamper;

    localparam int SIZE      = 3;
    localparam int PRECISION = 24;
    localparam int POINT     = 12;
    localparam int W         = PRECISION + POINT;
    localparam int NW        = 3;
    localparam int GND       = SIZE;
    localparam longint MAXV  = (64'sd1 <<< (W - 1)) - 1;
    localparam longint MINV  = -(64'sd1 <<< (W - 1));
    localparam longint ONE   = 64'sd1 <<< POINT;

    logic                     clk = 1'b0;
    logic                     I_RST = 1'b1;
    logic                     stamp_valid = 1'b0;
    logic                     stamp_ready;
    logic                     stamp_type = 1'b0;
    logic [NW-1:0]            stamp_node_a = '0;
    logic [NW-1:0]            stamp_node_b = '0;
    logic signed [W-1:0]      stamp_value = '0;
    logic                     stamp_last = 1'b0;
    logic [SIZE*SIZE*W-1:0]   A;
    logic [SIZE*W-1:0]        b;
    logic                     solver_rstn;
    logic                     frame_valid;
    logic                     frame_sat;
    logic                     frame_err;
    logic [15:0]              frame_count;

    int n_checks = 0;
    int n_fail   = 0;

    mna_stamper #(
        .SIZE(SIZE), .PRECISION(PRECISION), .POINT(POINT), .NW(NW)
    ) dut (
        .clk(clk), .I_RST(I_RST),
        .stamp_valid(stamp_valid), .stamp_ready(stamp_ready),
        .stamp_type(stamp_type), .stamp_node_a(stamp_node_a),
        .stamp_node_b(stamp_node_b), .stamp_value(stamp_value),
        .stamp_last(stamp_last),
        .A(A), .b(b), .solver_rstn(solver_rstn),
        .frame_valid(frame_valid), .frame_sat(frame_sat),
        .frame_err(frame_err), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic longint a_el(input int i, input int j);
        logic [W-1:0] s;
        s = A[(i*SIZE+j)*W +: W];
        return longint'($signed(s));
    endfunction

    function automatic longint b_el(input int i);
        logic [W-1:0] s;
        s = b[i*W +: W];
        return longint'($signed(s));
    endfunction

    // ---------------- behavioural model ----------------
    longint m_aw [SIZE][SIZE];
    longint m_bw [SIZE];
    longint m_pa [SIZE][SIZE];
    longint m_pb [SIZE];
    bit     m_sat, m_err, m_psat, m_perr, m_pvalid;
    bit     m_ready, m_rstn, m_commit, m_clear, m_known;
    int     m_count;
    int     mna, mnb;
    longint mv;

    function automatic longint sat_sum(input longint x, input longint d);
        longint s;
        s = x + d;
        if (s > MAXV) begin s = MAXV; m_sat = 1'b1; end
        if (s < MINV) begin s = MINV; m_sat = 1'b1; end
        return s;
    endfunction

    function automatic void zero_work();
        for (int i = 0; i < SIZE; i++) begin
            for (int j = 0; j < SIZE; j++) m_aw[i][j] = 0;
            m_bw[i] = 0;
        end
        m_sat = 1'b0;
        m_err = 1'b0;
    endfunction

    // Nodal-analysis stamp rules applied to the model's working set.
    function automatic void apply_stamp(input bit t, input int na, input int nb,
                                        input longint v);
        if (na > SIZE || nb > SIZE) begin
            m_err = 1'b1;
        end else if (na != nb) begin
            if (!t) begin
                if (na < SIZE) m_aw[na][na] = sat_sum(m_aw[na][na], v);
                if (nb < SIZE) m_aw[nb][nb] = sat_sum(m_aw[nb][nb], v);
                if (na < SIZE && nb < SIZE) begin
                    m_aw[na][nb] = sat_sum(m_aw[na][nb], -v);
                    m_aw[nb][na] = sat_sum(m_aw[nb][na], -v);
                end
            end else begin
                if (na < SIZE) m_bw[na] = sat_sum(m_bw[na], v);
                if (nb < SIZE) m_bw[nb] = sat_sum(m_bw[nb], -v);
            end
        end
    endfunction

    // Frame phases: reset, then one clearing cycle, accumulate until the last
    // stamp, one publish cycle, one clearing cycle with the solver held in reset.
    always @(posedge clk) begin
        if (I_RST) begin
            zero_work();
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++) m_pa[i][j] = 0;
                m_pb[i] = 0;
            end
            m_ready = 0; m_rstn = 1; m_commit = 0; m_clear = 1;
            m_pvalid = 0; m_psat = 0; m_perr = 0; m_count = 0; m_known = 1;
        end else if (m_commit) begin
            m_pa = m_aw;
            m_pb = m_bw;
            m_count  = (m_count + 1) & 16'hFFFF;
            m_pvalid = 1; m_psat = m_sat; m_perr = m_err;
            m_commit = 0; m_clear = 1; m_rstn = 0;
        end else if (m_clear) begin
            zero_work();
            m_clear = 0; m_ready = 1; m_rstn = 1;
        end else if (stamp_valid && m_ready) begin
            mna = int'(stamp_node_a);
            mnb = int'(stamp_node_b);
            mv  = longint'(stamp_value);
            apply_stamp(stamp_type, mna, mnb, mv);
            if (stamp_last) begin
                m_ready  = 0;
                m_commit = 1;
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (m_known) begin
            check("stamp_ready", stamp_ready, m_ready);
            check("solver_rstn", solver_rstn, m_rstn);
            check("frame_valid", frame_valid, m_pvalid);
            check("frame_sat", frame_sat, m_psat);
            check("frame_err", frame_err, m_perr);
            check("frame_count", frame_count, m_count);
            for (int i = 0; i < SIZE; i++) begin
                for (int j = 0; j < SIZE; j++)
                    check($sformatf("A[%0d][%0d]", i, j), a_el(i, j), m_pa[i][j]);
                check($sformatf("b[%0d]", i), b_el(i), m_pb[i]);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic send(input bit t, input int na, input int nb, input longint v,
                        input bit last);
        int n;
        n = 0;
        stamp_valid  = 1'b1;
        stamp_type   = t;
        stamp_node_a = NW'(na);
        stamp_node_b = NW'(nb);
        stamp_value  = W'(v);
        stamp_last   = last;
        while (!stamp_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("ready_wait_bound", (n < 20) ? 1 : 0, 1);
        @(negedge clk);
    endtask

    task automatic idle();
        stamp_valid = 1'b0;
        stamp_last  = 1'b0;
    endtask

    // Let a frame finish publishing and count solver reset pulses meanwhile.
    task automatic settle(input int exp_pulses, input string name);
        int lows;
        lows = 0;
        repeat (4) begin
            @(negedge clk);
            if (!solver_rstn) lows++;
        end
        check(name, lows, exp_pulses);
    endtask

    initial begin
        // 1: reset
        repeat (2) @(negedge clk);
        check("rst_A00", a_el(0, 0), 0);
        check("rst_b0", b_el(0), 0);
        check("rst_valid", frame_valid, 0);
        check("rst_count", frame_count, 0);
        check("rst_rstn", solver_rstn, 1);
        I_RST = 1'b0;
        check("rst_ready_lo", stamp_ready, 0);
        @(negedge clk);
        check("rst_ready_hi", stamp_ready, 1);

        // 2: solver frame
        send(0, 0, 1, ONE, 0);
        send(0, 1, 2, ONE, 0);
        send(0, 0, GND, 2 * ONE, 0);
        send(0, 1, GND, ONE, 0);
        send(0, 2, GND, ONE, 0);
        send(1, 0, GND, 52 * ONE, 0);
        send(1, 2, GND, 3 * ONE, 1);
        idle();
        settle(1, "f2_rstn_pulses");
        check("f2_A00", a_el(0, 0), 3 * 4096);
        check("f2_A01", a_el(0, 1), -4096);
        check("f2_A02", a_el(0, 2), 0);
        check("f2_A11", a_el(1, 1), 3 * 4096);
        check("f2_A12", a_el(1, 2), -4096);
        check("f2_A21", a_el(2, 1), -4096);
        check("f2_A22", a_el(2, 2), 2 * 4096);
        check("f2_b0", b_el(0), 52 * 4096);
        check("f2_b2", b_el(2), 3 * 4096);
        check("f2_valid", frame_valid, 1);
        check("f2_count", frame_count, 1);

        // 3: back-to-back frames, valid held through publish/clear
        send(0, 0, 1, 7, 1);
        send(1, 0, 1, 5, 0);
        send(0, 1, 1, 9, 0);
        send(0, GND, GND, 4, 0);
        send(1, 2, 0, -20, 0);
        send(0, 2, GND, 2, 1);
        idle();
        settle(1, "f3_rstn_pulses");
        check("f3_A00", a_el(0, 0), 0);
        check("f3_A11", a_el(1, 1), 0);
        check("f3_A22", a_el(2, 2), 2);
        check("f3_b0", b_el(0), 25);
        check("f3_b1", b_el(1), -5);
        check("f3_b2", b_el(2), -20);
        check("f3_err", frame_err, 0);
        check("f3_count", frame_count, 3);

        // 4: saturation, then a clean frame
        send(0, 0, GND, MAXV, 0);
        send(0, 0, GND, MAXV, 1);
        idle();
        settle(1, "f4_rstn_pulses");
        check("f4_A00", a_el(0, 0), 64'sd34359738367);
        check("f4_sat", frame_sat, 1);
        send(0, 0, 1, ONE, 1);
        idle();
        settle(1, "f4b_rstn_pulses");
        check("f4b_sat", frame_sat, 0);
        check("f4b_A01", a_el(0, 1), -4096);
        send(1, GND, 1, MAXV, 0);
        send(1, GND, 1, MAXV, 1);
        idle();
        settle(1, "f4c_rstn_pulses");
        check("f4c_b1", b_el(1), -64'sd34359738368);
        check("f4c_sat", frame_sat, 1);

        // 5: out-of-range node indices are dropped
        send(0, 0, 1, ONE, 0);
        send(0, 4, 0, 5 * ONE, 0);
        send(1, 2, 5, 9 * ONE, 0);
        send(1, 1, GND, 7 * ONE, 1);
        idle();
        settle(1, "f5_rstn_pulses");
        check("f5_err", frame_err, 1);
        check("f5_A00", a_el(0, 0), 4096);
        check("f5_A10", a_el(1, 0), -4096);
        check("f5_b1", b_el(1), 7 * 4096);
        check("f5_b2", b_el(2), 0);
        check("f5_count", frame_count, 7);

        // 6: reset mid-frame, then one fresh frame
        send(0, 0, 1, ONE, 0);
        send(0, 1, 2, ONE, 0);
        send(1, 0, GND, 4 * ONE, 0);
        idle();
        I_RST = 1'b1;
        settle(0, "f6_rstn_pulses");
        check("f6_A00", a_el(0, 0), 0);
        check("f6_b1", b_el(1), 0);
        check("f6_count", frame_count, 0);
        check("f6_valid", frame_valid, 0);
        I_RST = 1'b0;
        @(negedge clk);
        send(0, 2, 0, 3, 1);
        idle();
        settle(1, "f6b_rstn_pulses");
        check("f6b_A00", a_el(0, 0), 3);
        check("f6b_A02", a_el(0, 2), -3);
        check("f6b_A11", a_el(1, 1), 0);
        check("f6b_count", frame_count, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
